// File: rtl/alu_pkg.sv
// Shared definitions for the alu_mdu datapath.
// Contents: ALU operation codes, MDU operation codes and the MDU state encoding.
// It has no ports.
package alu_pkg;

  // Combinational ALU operation select. Codes 10-15 are unused and give C = 0.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_SRA  = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  // Multi-cycle unit operation select. Code 7 behaves like MDU_NONE.
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  // MDU control state.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/alu_mdu_if.sv
// Bus bundle between the EX stage and alu_mdu.
// Signals: A/B operands, ALUOp select, C combinational result, start/MDUOp request,
//          busy/done handshake, HI/LO registers.
// master: the stage driving requests; slave: the alu_mdu block.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] C;
  logic             start;
  logic [2:0]       MDUOp;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output A, B, ALUOp, start, MDUOp,
    input  C, busy, done, HI, LO
  );

  modport slave (
    input  A, B, ALUOp, start, MDUOp,
    output C, busy, done, HI, LO
  );
endinterface

// File: rtl/alu_mdu_core.sv
// mdu_core: multi-cycle multiply/divide unit with HI/LO registers.
// Ports: clk, reset (async, active-high), A/B operands, start/MDUOp request,
//        busy/done handshake (registered), HI/LO registers.
// The full result is computed when a request is accepted and held in pending
// registers; the counter only models the latency before it becomes visible.
module mdu_core
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_start,
  input  logic [2:0]       i_mdu_op,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pend_hi;
  logic [WIDTH-1:0] r_pend_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // Sign/zero-extended operands make a plain 2W-bit multiply exact in both cases.
  assign w_prod_s = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

  // Result selection; divide-by-zero and signed overflow are pinned explicitly
  // so the divider never sees an undefined case.
  always_comb begin
    w_res_hi = {WIDTH{1'b0}};
    w_res_lo = {WIDTH{1'b0}};
    case (i_mdu_op)
      MDU_MULT: begin
        w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_s[WIDTH-1:0];
      end
      MDU_MULTU: begin
        w_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_u[WIDTH-1:0];
      end
      MDU_DIV: begin
        if (i_b == {WIDTH{1'b0}}) begin
          w_res_hi = i_a;
          w_res_lo = {WIDTH{1'b1}};
        end else if ((i_a == MOST_NEG) && (i_b == {WIDTH{1'b1}})) begin
          w_res_hi = {WIDTH{1'b0}};
          w_res_lo = i_a;
        end else begin
          w_res_hi = $signed(i_a) % $signed(i_b);
          w_res_lo = $signed(i_a) / $signed(i_b);
        end
      end
      MDU_DIVU: begin
        if (i_b == {WIDTH{1'b0}}) begin
          w_res_hi = i_a;
          w_res_lo = {WIDTH{1'b1}};
        end else begin
          w_res_hi = i_a % i_b;
          w_res_lo = i_a / i_b;
        end
      end
      default: begin
        w_res_hi = {WIDTH{1'b0}};
        w_res_lo = {WIDTH{1'b0}};
      end
    endcase
  end

  // Control FSM: accept, count down, commit with a one-cycle done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= {CW{1'b0}};
      r_pend_hi <= {WIDTH{1'b0}};
      r_pend_lo <= {WIDTH{1'b0}};
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            case (i_mdu_op)
              MDU_MULT, MDU_MULTU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_cnt     <= CW'(MUL_CYCLES);
                r_busy    <= 1'b1;
                r_state   <= BUSY;
              end
              MDU_DIV, MDU_DIVU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_cnt     <= CW'(DIV_CYCLES);
                r_busy    <= 1'b1;
                r_state   <= BUSY;
              end
              MDU_MTHI: r_hi <= i_a;
              MDU_MTLO: r_lo <= i_a;
              default:  ; // none / code 7: no effect
            endcase
          end
        end
        BUSY: begin
          // Requests arriving here are dropped on purpose.
          if (r_cnt == CW'(1)) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage datapath with a zero-latency ALU and a multi-cycle MDU.
// Ports: clk, reset (async, active-high), bus (alu_mdu_if slave: A, B, ALUOp -> C;
//        start, MDUOp -> busy, done, HI, LO).
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic     clk,
  input  logic     reset,
  alu_mdu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_c;

  // Only the low log2(WIDTH) bits of B select the shift distance.
  assign w_shamt = bus.B[SHW-1:0];

  // Combinational ALU result.
  always_comb begin
    w_c = {WIDTH{1'b0}};
    case (bus.ALUOp)
      ALU_ADD:  w_c = bus.A + bus.B;
      ALU_SUB:  w_c = bus.A - bus.B;
      ALU_AND:  w_c = bus.A & bus.B;
      ALU_OR:   w_c = bus.A | bus.B;
      ALU_SRL:  w_c = bus.A >> w_shamt;
      ALU_SRA:  w_c = $signed(bus.A) >>> w_shamt;
      ALU_XOR:  w_c = bus.A ^ bus.B;
      ALU_SLL:  w_c = bus.A << w_shamt;
      ALU_SLT:  w_c = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      ALU_SLTU: w_c = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      default:  w_c = {WIDTH{1'b0}};
    endcase
  end

  assign bus.C = w_c;

  mdu_core #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_core (
    .clk      (clk),
    .reset    (reset),
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_start  (bus.start),
    .i_mdu_op (bus.MDUOp),
    .o_busy   (bus.busy),
    .o_done   (bus.done),
    .o_hi     (bus.HI),
    .o_lo     (bus.LO)
  );

endmodule
